// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, syncs, active window, preload and row pulses.
// Define VTG_PAL_PAD_EN to shift the PAL active window down by PAL_PAD lines.
module video_timing_gen #(
    parameter int H_TOTAL      = 228,
    parameter int H_SYNC       = 16,
    parameter int H_ACT_START  = 40,
    parameter int PRELOAD_LEAD = 2,
    parameter int V_TOTAL_NTSC = 262,
    parameter int V_TOTAL_PAL  = 312,
    parameter int V_FS_LINES   = 3,
    parameter int V_ACT_START  = 40,
    parameter int ACTIVE_LINES = 192,
    parameter int ROW_LINES    = 12,
    parameter int PAL_PAD      = 25,
    parameter int H_W          = 9,
    parameter int V_W          = 9
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           format_req,
    output logic           format,
    output logic           hsn,
    output logic           fsn,
    output logic           preload,
    output logic           rowclear,
    output logic           active,
    output logic [H_W-1:0] h_count,
    output logic [V_W-1:0] v_count,
    output logic [3:0]     row_line,
    output logic           format_changed
);

    localparam logic [H_W-1:0] H_LAST  = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_SYNC_C = H_W'(H_SYNC);
    localparam logic [H_W-1:0] H_ACT_C = H_W'(H_ACT_START);
    localparam logic [H_W-1:0] H_PRE_C = H_W'(H_ACT_START - PRELOAD_LEAD);
    localparam logic [V_W-1:0] V_LAST_N = V_W'(V_TOTAL_NTSC - 1);
    localparam logic [V_W-1:0] V_LAST_P = V_W'(V_TOTAL_PAL - 1);
    localparam logic [V_W-1:0] V_FS_C  = V_W'(V_FS_LINES);
    localparam logic [V_W-1:0] VS_BASE = V_W'(V_ACT_START);
    localparam logic [V_W-1:0] VS_PAD  = V_W'(V_ACT_START + PAL_PAD);
    localparam logic [V_W-1:0] V_ACT_N = V_W'(ACTIVE_LINES);
    localparam logic [3:0]     ROW_LAST = 4'(ROW_LINES - 1);

`ifdef VTG_PAL_PAD_EN
    localparam logic PAD_EN = 1'b1;
`else
    localparam logic PAD_EN = 1'b0;
`endif

    logic           h_wrap;
    logic           f_wrap;
    logic           fmt_nx;
    logic           vact_nx;
    logic [H_W-1:0] h_nx;
    logic [V_W-1:0] v_nx;
    logic [V_W-1:0] v_last;
    logic [V_W-1:0] vs_nx;
    logic [V_W-1:0] v_rel;
    logic [3:0]     row_nx;

    // Everything is derived from next-state counters so outputs align with them.
    always_comb begin
        h_wrap = (h_count == H_LAST);
        v_last = format ? V_LAST_P : V_LAST_N;
        f_wrap = h_wrap && (v_count == v_last);
        h_nx   = h_wrap ? '0 : h_count + 1'b1;
        v_nx   = v_count;
        if (h_wrap) begin
            v_nx = f_wrap ? '0 : v_count + 1'b1;
        end
        fmt_nx  = f_wrap ? format_req : format;
        vs_nx   = (PAD_EN && fmt_nx) ? VS_PAD : VS_BASE;
        v_rel   = v_nx - vs_nx;
        vact_nx = (v_nx >= vs_nx) && (v_rel < V_ACT_N);
        row_nx  = row_line;
        if (!vact_nx) begin
            row_nx = '0;
        end else if (h_wrap) begin
            if (v_nx == vs_nx || row_line == ROW_LAST) begin
                row_nx = '0;
            end else begin
                row_nx = row_line + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_count        <= '0;
            v_count        <= '0;
            row_line       <= '0;
            format         <= 1'b0;
            format_changed <= 1'b0;
            preload        <= 1'b0;
            rowclear       <= 1'b0;
            active         <= 1'b0;
            hsn            <= 1'b0;
            fsn            <= 1'b0;
        end else begin
            h_count        <= h_nx;
            v_count        <= v_nx;
            row_line       <= row_nx;
            format         <= fmt_nx;
            format_changed <= f_wrap && (format_req != format);
            preload        <= vact_nx && (h_nx == H_PRE_C);
            rowclear       <= vact_nx && (h_nx == '0) && (row_nx == '0);
            active         <= vact_nx && (h_nx >= H_ACT_C);
            hsn            <= (h_nx >= H_SYNC_C);
            fsn            <= (v_nx >= V_FS_C);
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: cycle-by-cycle check against a raster model.
module tb_video_timing_gen;

    localparam int HT = 104;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       format_req = 1'b0;
    logic       format, hsn, fsn, preload, rowclear, active, format_changed;
    logic [8:0] h_count, v_count;
    logic [3:0] row_line;

    int checks = 0;
    int errors = 0;

    int mh = 0;
    int mv = 0;
    bit mfmt = 1'b0;
    bit mchg = 1'b0;

    video_timing_gen #(.H_TOTAL(HT)) dut (
        .clk(clk), .reset(reset), .format_req(format_req),
        .format(format), .hsn(hsn), .fsn(fsn),
        .preload(preload), .rowclear(rowclear), .active(active),
        .h_count(h_count), .v_count(v_count), .row_line(row_line),
        .format_changed(format_changed)
    );

    always #5 clk = ~clk;

    function automatic int vtot(bit f);
        return f ? 312 : 262;
    endfunction

    function automatic int vstart(bit f);
`ifdef VTG_PAL_PAD_EN
        return f ? 65 : 40;
`else
        return 40;
`endif
    endfunction

    function automatic logic [28:0] expv();
        int  vs;
        bit  vact;
        int  row;
        vs   = vstart(mfmt);
        vact = (mv >= vs) && (mv < vs + 192);
        row  = vact ? (mv - vs) % 12 : 0;
        return {mfmt, 1'(mh >= 16), 1'(mv >= 3),
                1'(vact && mh == 38), 1'(vact && mh == 0 && row == 0),
                1'(vact && mh >= 40), 9'(mh), 9'(mv), 4'(row), mchg};
    endfunction

    function automatic logic [28:0] obs();
        return {format, hsn, fsn, preload, rowclear, active,
                h_count, v_count, row_line, format_changed};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            mh = 0; mv = 0; mfmt = 1'b0; mchg = 1'b0;
        end else begin
            mchg = 1'b0;
            if (mh == HT - 1) begin
                mh = 0;
                if (mv == vtot(mfmt) - 1) begin
                    mv   = 0;
                    mchg = (format_req != mfmt);
                    mfmt = format_req;
                end else begin
                    mv++;
                end
            end else begin
                mh++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat ($urandom_range(2, 5)) begin
            format_req = 1'($urandom);
            tick();
        end
        checks++;
        if (obs() !== 29'h0 && {hsn, fsn} !== 2'b00) begin
            errors++;
            $display("FAIL reset_syncs: got %b want 00", {hsn, fsn});
        end
        checks++;
        if ({h_count, v_count, row_line, format, format_changed,
             preload, rowclear, active, hsn, fsn} !== 29'h0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0", obs());
        end
        checks++;
        if (obs() !== expv()) begin
            errors++;
            $display("FAIL reset_model: got %h want %h", obs(), expv());
        end
        reset = 1'b0;
        format_req = 1'b0;
    endtask

    task automatic test_ntsc_frame();
        int bad = 0, npre = 0, nrc = 0, hs_low = 0, fs_lines = 0;
        int pre_first = -1, pre_last = -1, rc_first = -1, rc_last = -1;
        int pre_badh = 0, vmax = 0, f1 = 0;
        logic [28:0] fo = '0, fe = '0;
        for (int i = 0; i < 262 * HT; i++) begin
            format_req = (mv >= 100) ? 1'b1 : 1'($urandom);
            tick();
            if (obs() !== expv()) begin
                if (bad == 0) begin fo = obs(); fe = expv(); end
                bad++;
            end
            if (preload) begin
                npre++;
                if (pre_first < 0) pre_first = int'(v_count);
                pre_last = int'(v_count);
                if (h_count != 9'd38) pre_badh++;
            end
            if (rowclear) begin
                nrc++;
                if (rc_first < 0) rc_first = int'(v_count);
                rc_last = int'(v_count);
            end
            if (!hsn) hs_low++;
            if (!fsn && h_count == 9'd0) fs_lines++;
            if (int'(v_count) > vmax) vmax = int'(v_count);
            if (i < 262 * HT - 1 && format) f1++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ntsc_trace: %0d bad cycles, first got %h want %h", bad, fo, fe);
        end
        checks++;
        if (npre != 192 || pre_first != 40 || pre_last != 231 || pre_badh != 0) begin
            errors++;
            $display("FAIL ntsc_preload: got n=%0d lines %0d..%0d badh=%0d want 192 40..231 0",
                     npre, pre_first, pre_last, pre_badh);
        end
        checks++;
        if (nrc != 16 || rc_first != 40 || rc_last != 220) begin
            errors++;
            $display("FAIL ntsc_rowclear: got n=%0d lines %0d..%0d want 16 40..220",
                     nrc, rc_first, rc_last);
        end
        checks++;
        if (hs_low != 16 * 262 || fs_lines != 3) begin
            errors++;
            $display("FAIL ntsc_syncs: got hs_low=%0d fs=%0d want %0d 3", hs_low, fs_lines, 16 * 262);
        end
        checks++;
        if (vmax != 261 || f1 != 0) begin
            errors++;
            $display("FAIL ntsc_wrap: got vmax=%0d early_fmt=%0d want 261 0", vmax, f1);
        end
        checks++;
        if ({format, format_changed, v_count, h_count} !== {1'b1, 1'b1, 18'h0}) begin
            errors++;
            $display("FAIL fmt_switch: got fmt=%b chg=%b v=%0d want 1 1 0",
                     format, format_changed, v_count);
        end
        tick();
        checks++;
        if (format_changed !== 1'b0 || format !== 1'b1) begin
            errors++;
            $display("FAIL fmt_pulse: got chg=%b fmt=%b want 0 1", format_changed, format);
        end
    endtask

    task automatic test_pal_frame();
        int bad = 0, nchg = 0, vmax = 0, npre = 0;
        int a_first = -1, a_last = -1;
        int want_first, want_last;
        logic [28:0] fo = '0, fe = '0;
`ifdef VTG_PAL_PAD_EN
        want_first = 65; want_last = 256;
`else
        want_first = 40; want_last = 231;
`endif
        for (int i = 0; i < 312 * HT - 1; i++) begin
            if (mv < 10) format_req = 1'b1;
            else if (mv < 20) format_req = 1'b0;
            else if (mv < 300) format_req = (mv < 30) ? 1'b1 : 1'($urandom);
            else format_req = 1'b1;
            tick();
            if (obs() !== expv()) begin
                if (bad == 0) begin fo = obs(); fe = expv(); end
                bad++;
            end
            if (active) begin
                if (a_first < 0) a_first = int'(v_count);
                a_last = int'(v_count);
            end
            if (preload) npre++;
            if (format_changed) nchg++;
            if (int'(v_count) > vmax) vmax = int'(v_count);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL pal_trace: %0d bad cycles, first got %h want %h", bad, fo, fe);
        end
        checks++;
        if (a_first != want_first || a_last != want_last || npre != 192) begin
            errors++;
            $display("FAIL pal_active: got %0d..%0d n=%0d want %0d..%0d 192",
                     a_first, a_last, npre, want_first, want_last);
        end
        checks++;
        if (nchg != 0 || vmax != 311) begin
            errors++;
            $display("FAIL pal_wrap: got chg=%0d vmax=%0d want 0 311", nchg, vmax);
        end
        checks++;
        if ({format, v_count, h_count} !== {1'b1, 18'h0}) begin
            errors++;
            $display("FAIL pal_end: got fmt=%b v=%0d h=%0d want 1 0 0", format, v_count, h_count);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0, n = 0;
        logic [28:0] fo = '0, fe = '0;
        format_req = 1'b1;
        while (!(mv == 150 && mh == 100) && n < 400 * HT) begin
            tick();
            n++;
            if (obs() !== expv()) begin
                if (bad == 0) begin fo = obs(); fe = expv(); end
                bad++;
            end
        end
        checks++;
        if ({format, v_count, h_count} !== {1'b1, 9'd150, 9'd100}) begin
            errors++;
            $display("FAIL mid_reach: got fmt=%b v=%0d h=%0d want 1 150 100",
                     format, v_count, h_count);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({h_count, v_count, row_line, format, format_changed,
             preload, rowclear, active, hsn, fsn} !== 29'h0) begin
            errors++;
            $display("FAIL mid_reset: got %h want 0", obs());
        end
        repeat ($urandom_range(0, 3)) tick();
        reset = 1'b0;
        format_req = 1'b0;
        tick();
        checks++;
        if ({format, v_count, h_count} !== {1'b0, 9'd0, 9'd1}) begin
            errors++;
            $display("FAIL mid_resume: got fmt=%b v=%0d h=%0d want 0 0 1",
                     format, v_count, h_count);
        end
        for (int i = 0; i < 50 * HT; i++) begin
            format_req = 1'($urandom);
            tick();
            if (obs() !== expv()) begin
                if (bad == 0) begin fo = obs(); fe = expv(); end
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mid_trace: %0d bad cycles, first got %h want %h", bad, fo, fe);
        end
    endtask

    initial begin
        test_reset();
        test_ntsc_frame();
        test_pal_frame();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_TOTAL, default 228, pixel-clock cycles per line.
REQ-002 SHALL have parameter H_SYNC, default 16, hsn low width in cycles.
REQ-003 SHALL have parameter H_ACT_START, default 40, first active cycle of a line.
REQ-004 SHALL have parameter PRELOAD_LEAD, default 2, cycles before H_ACT_START at which preload pulses.
REQ-005 SHALL have parameters V_TOTAL_NTSC, default 262, and V_TOTAL_PAL, default 312, lines per frame per format.
REQ-006 SHALL have parameters V_FS_LINES, default 3, fsn low lines; V_ACT_START, default 40; ACTIVE_LINES, default 192; ROW_LINES, default 12; PAL_PAD, default 25.
REQ-007 SHALL have parameters H_W, default 9, and V_W, default 9, counter widths.
REQ-008 SHALL have ports: clk input 1, pixel clock; reset input 1, synchronous active-high reset.
REQ-009 SHALL have ports: format_req input 1, requested format (0 NTSC, 1 PAL); format input 1 is not present (format_req only).
REQ-010 SHALL have outputs: format output 1, active format; hsn output 1, horizontal sync, active low; fsn output 1, field sync, active low.
REQ-011 SHALL have outputs: preload output 1, data preload pulse; rowclear output 1, character-row start pulse; active output 1, active display.
REQ-012 SHALL have outputs: h_count output H_W, v_count output V_W, row_line output 4, format_changed output 1.

Function
REQ-013 h_count SHALL increment each clk, wrapping H_TOTAL-1 -> 0; v_count SHALL increment on h wrap, wrapping V_TOTAL(format)-1 -> 0.
REQ-014 All outputs SHALL be registered, consistent with h_count/v_count in the same cycle (zero relative latency).
REQ-015 hsn SHALL be 0 iff h_count < H_SYNC.
REQ-016 fsn SHALL be 0 iff v_count < V_FS_LINES.
REQ-017 Effective active start VS SHALL be V_ACT_START, plus PAL_PAD when format=1 and VTG_PAL_PAD_EN is defined.
REQ-018 active SHALL be 1 iff VS <= v_count < VS+ACTIVE_LINES and h_count >= H_ACT_START.
REQ-019 preload SHALL pulse for one cycle at h_count = H_ACT_START-PRELOAD_LEAD on every active line.
REQ-020 row_line SHALL be 0 on line VS, increment per active line, wrap ROW_LINES-1 -> 0, and hold 0 outside active lines.
REQ-021 rowclear SHALL pulse for one cycle at h_count=0 on each active line where row_line=0.
REQ-022 format_req SHALL be sampled only in cycle h_count=H_TOTAL-1, v_count=V_TOTAL(format)-1; format updates on the next clk, simultaneously with v_count -> 0.
REQ-023 format_changed SHALL pulse one cycle when format takes a new value; a request toggled and restored within one frame SHALL cause no change.
REQ-024 V_TOTAL used for the wrap SHALL be that of the currently active format, never format_req.

Reset
REQ-025 reset SHALL force, on the next clk, h_count=0, v_count=0, row_line=0, format=0, format_changed=0, preload=0, rowclear=0, active=0, hsn=0, fsn=0.
REQ-026 reset asserted mid-frame SHALL discard pending format requests; counting resumes from 0 on the first clk after release.

Configuration
REQ-027 With macro VTG_PAL_PAD_EN defined, PAL active region SHALL be offset by PAL_PAD lines (centred picture); without it, PAL uses V_ACT_START and extra lines appear only after the active region.

Verification
REQ-028 Reset, format_req=0, run 262*228 cycles -> v_count wraps 261->0, fsn low for lines 0..2, hsn low h_count 0..15 each line.
REQ-029 NTSC frame -> preload at h_count=38 on lines 40..231 only; rowclear on lines 40,52,...,220 (16 pulses).
REQ-030 Assert format_req=1 at line 100 -> format stays 0 until v_count wraps at 261, then format=1, format_changed one pulse, next frame wraps at 311.
REQ-031 PAL with VTG_PAL_PAD_EN -> first active line 65, last 256; without macro -> 40..231.
REQ-032 Assert reset at v_count=150, h_count=100 with format=1 -> next cycle all counters 0, format=0; resumes NTSC timing.
REQ-033 Pulse format_req 1 at line 10 and back to 0 at line 20 -> no format change, no format_changed pulse.
